// File: rtl/counter_pkg.sv
// Shared definitions for the LED counter run controller.
//   run_state_t : FSM encoding, also driven onto the state output port
//   RATEn_DEF   : default prescaler terminal values for a 50 MHz clock
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } run_state_t;

  localparam int unsigned RATE0_DEF = 24999999;  // 2 Hz
  localparam int unsigned RATE1_DEF = 4999999;   // 10 Hz
  localparam int unsigned RATE2_DEF = 499999;    // 100 Hz
  localparam int unsigned RATE3_DEF = 49999;     // 1 kHz

endpackage

// File: rtl/counter_run_controller_btn_edge_sync.sv
// Button synchronizer and rising-edge detector.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : debounced button level, asynchronous to clk
//   pulse      : registered one-cycle event; a rise sampled at edge N
//                is visible to downstream logic at edge N+3
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic btn_p0;
  logic btn_p1;
  logic btn_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      btn_p2 <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      // p0/p1: metastability chain
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      // p2: previous synchronized level for edge detect
      btn_p2 <= btn_p1;
      pulse  <= btn_p1 & ~btn_p2;
    end
  end

endmodule

// File: rtl/counter_run_controller.sv
// Run/pause/clear sequencer for the 12-bit LED counter.
//   clk, reset            : system clock, synchronous active-high reset
//   btn_run/clear/dir     : debounced button levels (asynchronous)
//   rate_sel              : selects one of four prescaler terminal values
//   oneshot               : 1 = stop in DONE at terminal count, 0 = wrap
//   count_in              : current counter value
//   cnt_init              : counter synchronous clear (registered)
//   cnt_enable            : one-cycle count pulse (registered)
//   cnt_down              : count direction, 1 = down (registered)
//   state                 : FSM state, IDLE=00 RUN=01 PAUSE=10 DONE=11
module counter_run_controller
  import counter_pkg::*;
#(
  parameter int          PRESCALE_W = 25,
  parameter int          COUNT_W    = 12,
  parameter int unsigned RATE0      = RATE0_DEF,
  parameter int unsigned RATE1      = RATE1_DEF,
  parameter int unsigned RATE2      = RATE2_DEF,
  parameter int unsigned RATE3      = RATE3_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_clear,
  input  logic               btn_dir,
  input  logic [1:0]         rate_sel,
  input  logic               oneshot,
  input  logic [COUNT_W-1:0] count_in,
  output logic               cnt_init,
  output logic               cnt_enable,
  output logic               cnt_down,
  output logic [1:0]         state
);

  logic                  run_ev;
  logic                  clear_ev;
  logic                  dir_ev;
  run_state_t            state_q;
  run_state_t            state_n;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PRESCALE_W-1:0] limit;
  logic                  tick;
  logic                  terminal;
  logic                  init_req;
  logic                  toggle_dir;
  logic                  rst_hold;

  btn_edge_sync u_sync_run   (.clk(clk), .reset(reset), .btn(btn_run),   .pulse(run_ev));
  btn_edge_sync u_sync_clear (.clk(clk), .reset(reset), .btn(btn_clear), .pulse(clear_ev));
  btn_edge_sync u_sync_dir   (.clk(clk), .reset(reset), .btn(btn_dir),   .pulse(dir_ev));

  always_comb begin
    limit = PRESCALE_W'(RATE0);
    case (rate_sel)
      2'd0:    limit = PRESCALE_W'(RATE0);
      2'd1:    limit = PRESCALE_W'(RATE1);
      2'd2:    limit = PRESCALE_W'(RATE2);
      default: limit = PRESCALE_W'(RATE3);
    endcase
  end

  // ">=" so that lowering the rate limit below the current count ticks at once
  assign tick     = (state_q == ST_RUN) && (presc_cnt >= limit);
  assign terminal = cnt_down ? (count_in == '0) : (count_in == '1);

  // Event priority: clear, then run, then terminal stop, then direction.
  always_comb begin
    state_n    = state_q;
    init_req   = 1'b0;
    toggle_dir = 1'b0;
    if (clear_ev) begin
      if (state_q != ST_IDLE) begin
        state_n  = ST_IDLE;
        init_req = 1'b1;
      end
    end else if (run_ev) begin
      case (state_q)
        ST_IDLE:  state_n = ST_RUN;
        ST_RUN:   state_n = ST_PAUSE;
        ST_PAUSE: state_n = ST_RUN;
        default: begin
          state_n  = ST_RUN;
          init_req = 1'b1;
        end
      endcase
    end else if (tick && oneshot && terminal) begin
      state_n = ST_DONE;
    end else if (dir_ev && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      toggle_dir = 1'b1;
    end
  end

  // Prescaler: advances only while RUN persists, so a pause freezes it
  // (even at the limit, which then ticks immediately on resume).
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (init_req || state_q == ST_IDLE) begin
      presc_cnt <= '0;
    end else if (state_q == ST_RUN && state_n == ST_RUN) begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
    end
  end

  // Output registers; rst_hold stretches cnt_init one cycle past reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_enable <= 1'b0;
      cnt_down   <= 1'b0;
      cnt_init   <= 1'b1;
      rst_hold   <= 1'b1;
    end else begin
      state_q    <= state_n;
      rst_hold   <= 1'b0;
      cnt_init   <= rst_hold | init_req;
      cnt_enable <= tick && (state_n == ST_RUN);
      if (toggle_dir) begin
        cnt_down <= ~cnt_down;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_run_controller.sv
module tb_counter_run_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run;
  logic       btn_clear;
  logic       btn_dir;
  logic [1:0] rate_sel;
  logic       oneshot;
  logic [3:0] count_in;
  logic       cnt_init;
  logic       cnt_enable;
  logic       cnt_down;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] pat;

  always #5 clk = ~clk;

  counter_run_controller #(
    .PRESCALE_W(25),
    .COUNT_W   (4),
    .RATE0     (3),
    .RATE1     (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .btn_dir   (btn_dir),
    .rate_sel  (rate_sel),
    .oneshot   (oneshot),
    .count_in  (count_in),
    .cnt_init  (cnt_init),
    .cnt_enable(cnt_enable),
    .cnt_down  (cnt_down),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Capture cnt_enable over n cycles, bit k = cycle k+1.
  task automatic win(input int n, output logic [31:0] p);
    p = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      p[k] = cnt_enable;
    end
  endtask

  // One-cycle button press; returns one edge before the FSM reacts.
  task automatic btn_pulse(input logic r, input logic c, input logic d);
    btn_run   = r;
    btn_clear = c;
    btn_dir   = d;
    step(1);
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_dir   = 1'b0;
    step(2);
  endtask

  initial begin
    reset     = 1'b1;
    btn_run   = 1'b0;
    btn_clear = 1'b0;
    btn_dir   = 1'b0;
    rate_sel  = 2'd0;
    oneshot   = 1'b0;
    count_in  = 4'h5;

    // 1: reset and release
    step(2);
    chk("init_in_reset", cnt_init, 1);
    reset = 1'b0;
    step(1);
    chk("init_after_release", cnt_init, 1);
    chk("state_reset", state, 2'b00);
    chk("enable_reset", cnt_enable, 0);
    chk("down_reset", cnt_down, 0);
    step(1);
    chk("init_drops", cnt_init, 0);

    // 2: start, rate 0 then rate 1
    btn_pulse(1, 0, 0);
    chk("run_latency_early", state, 2'b00);
    step(1);
    chk("run_entered", state, 2'b01);
    win(12, pat);
    chk("rate0_pattern", pat, 32'h888);
    rate_sel = 2'd1;
    win(16, pat);
    chk("rate1_pattern", pat, 32'h8080);

    // 3: pause mid-count and resume
    btn_pulse(1, 0, 0);
    step(1);
    chk("pause_entered", state, 2'b10);
    win(6, pat);
    chk("pause_no_enable", pat, 32'h0);
    btn_pulse(1, 0, 0);
    chk("still_paused", state, 2'b10);
    step(1);
    chk("resumed", state, 2'b01);
    win(13, pat);
    chk("resume_remaining", pat, 32'h1010);

    // 4: oneshot stop at 0xF and restart
    rate_sel = 2'd0;
    oneshot  = 1'b1;
    count_in = 4'hF;
    win(4, pat);
    chk("done_no_enable", pat, 32'h0);
    chk("done_entered", state, 2'b11);
    step(2);
    chk("done_holds", state, 2'b11);
    btn_pulse(1, 0, 0);
    chk("done_init_low", cnt_init, 0);
    step(1);
    chk("restart_state", state, 2'b01);
    chk("restart_init", cnt_init, 1);
    oneshot  = 1'b0;
    count_in = 4'h5;
    step(1);
    chk("restart_init_pulse", cnt_init, 0);

    // 5: clear and run together
    btn_pulse(1, 1, 0);
    step(1);
    chk("clr_run_state", state, 2'b00);
    chk("clr_run_init", cnt_init, 1);
    chk("clr_run_enable", cnt_enable, 0);
    step(1);
    chk("clr_init_pulse", cnt_init, 0);
    step(3);
    chk("run_dropped", state, 2'b00);

    // 6: direction handling
    btn_pulse(1, 0, 0);
    step(1);
    chk("dir_run_state", state, 2'b01);
    btn_pulse(0, 0, 1);
    step(1);
    chk("dir_ignored_run", cnt_down, 0);
    btn_pulse(1, 0, 0);
    step(1);
    chk("dir_pause_state", state, 2'b10);
    btn_pulse(0, 0, 1);
    step(1);
    chk("dir_toggled", cnt_down, 1);
    chk("dir_stays_paused", state, 2'b10);
    oneshot  = 1'b1;
    count_in = 4'h0;
    btn_pulse(1, 0, 0);
    step(1);
    chk("down_resumed", state, 2'b01);
    step(1);
    chk("down_done", state, 2'b11);
    chk("down_done_enable", cnt_enable, 0);

    // reset from DONE
    reset = 1'b1;
    step(1);
    chk("reset_state", state, 2'b00);
    chk("reset_init", cnt_init, 1);
    chk("reset_down", cnt_down, 0);
    reset = 1'b0;
    step(2);
    chk("reset_init_clears", cnt_init, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
